// File: rtl/mul_defs_pkg.sv
// Shared multiplier definitions: FSM state encodings and the default operand width
// that the multiplier and the ALU adder agree on.
package mul_defs;

    localparam int MUL_N = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEG_A = 3'd1,
        ST_NEG_B = 3'd2,
        ST_STEP  = 3'd3,
        ST_NEG_P = 3'd4,
        ST_DONE  = 3'd5
    } mul_state_e;

endpackage

// File: rtl/Adder.sv
// Shared combinational adder, time-shared between the ALU and the sequential multiplier.
// Carry-out is deliberately not produced; all users work modulo 2^N.
module Adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_augend,
    input  logic [N-1:0] i_addend,
    output logic [N-1:0] o_sum
);

    assign o_sum = i_augend + i_addend;

endmodule

// File: rtl/booth_free_seq_multiplier.sv
// Sequential N x N shift-and-add multiplier with signed/unsigned mode and 2N-bit product.
// Sign handling is by magnitude: negate operands up front, negate the product at the end.
module booth_free_seq_multiplier
    import mul_defs::*;
#(
    parameter int N = MUL_N
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic           i_signed,
    input  logic [N-1:0]   i_multiplicand,
    input  logic [N-1:0]   i_multiplier,
    output logic           o_busy,
    output logic           o_finished,
    output logic [2*N-1:0] o_product,
    output logic           o_overflow,
    output logic [2*N-1:0] o_adder_augend,
    output logic [2*N-1:0] o_adder_addend,
    input  logic [2*N-1:0] i_adder_sum
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

    mul_state_e     state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  count_q, count_d;
    logic           neg_q, neg_d;
    logic           signed_q, signed_d;
    logic [2*N-1:0] product_q, product_d;
    logic           overflow_q, overflow_d;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            neg_q      <= 1'b0;
            signed_q   <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            neg_q      <= neg_d;
            signed_q   <= signed_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        acc_d          = acc_q;
        count_d        = count_q;
        neg_d          = neg_q;
        signed_d       = signed_q;
        product_d      = product_q;
        overflow_d     = overflow_q;
        o_adder_augend = '0;
        o_adder_addend = '0;
        o_finished     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_d      = i_multiplicand;
                    b_d      = i_multiplier;
                    signed_d = i_signed;
                    neg_d    = i_signed & (i_multiplicand[N-1] ^ i_multiplier[N-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    if (i_signed && i_multiplicand[N-1])
                        state_d = ST_NEG_A;
                    else if (i_signed && i_multiplier[N-1])
                        state_d = ST_NEG_B;
                    else
                        state_d = ST_STEP;
                end
            end
            // Two's-complement negation; the most negative value maps to itself,
            // which is the correct magnitude when read as unsigned.
            ST_NEG_A: begin
                o_adder_augend = {{N{1'b0}}, ~a_q};
                o_adder_addend = ONE;
                a_d            = i_adder_sum[N-1:0];
                state_d        = (signed_q && b_q[N-1]) ? ST_NEG_B : ST_STEP;
            end
            ST_NEG_B: begin
                o_adder_augend = {{N{1'b0}}, ~b_q};
                o_adder_addend = ONE;
                b_d            = i_adder_sum[N-1:0];
                state_d        = ST_STEP;
            end
            ST_STEP: begin
                o_adder_augend = acc_q;
                o_adder_addend = b_q[0] ? ({{N{1'b0}}, a_q} << count_q) : '0;
                acc_d          = i_adder_sum;
                b_d            = b_q >> 1;
                count_d        = count_q + 1'b1;
                if (count_q == CW'(N-1))
                    state_d = neg_q ? ST_NEG_P : ST_DONE;
            end
            ST_NEG_P: begin
                o_adder_augend = ~acc_q;
                o_adder_addend = ONE;
                acc_d          = i_adder_sum;
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                o_finished = 1'b1;
                product_d  = acc_q;
                // Signed fit means the top N+1 bits are pure sign extension.
                if (signed_q)
                    overflow_d = !((&acc_q[2*N-1:N-1]) || !(|acc_q[2*N-1:N-1]));
                else
                    overflow_d = |acc_q[2*N-1:N];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_product  = product_q;
    assign o_overflow = overflow_q;

endmodule
